// File: rtl/pn3_checker.sv
// PN3 receive checker: self-synchronises to a 0011101 stream, locks, then
// tracks with a free-running reference while counting bits and bit errors.
module pn3_checker #(
  parameter int unsigned LOCK_COUNT = 7,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       pn_seed
);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, LOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [7:0]       LOCK_N  = 8'(LOCK_COUNT);
  localparam logic [7:0]       LOSS_N  = 8'(LOSS_COUNT);

  state_t     state;
  logic [2:0] sr;
  logic [1:0] load_cnt;
  logic [7:0] match_cnt;
  logic [7:0] miss_cnt;

  logic       pred;
  logic [2:0] sr_shift;
  logic [1:0] load_nxt;

  assign pred     = sr[2] ^ sr[0];
  assign sr_shift = {sr[1:0], bit_in};
  assign load_nxt = (load_cnt == 2'd3) ? 2'd3 : load_cnt + 2'd1;
  assign pn_seed  = sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= 3'b000;
      load_cnt  <= 2'd0;
      match_cnt <= 8'd0;
      miss_cnt  <= 8'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      bit_count <= '0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (!enable) begin
        state     <= IDLE;
        sr        <= 3'b000;
        load_cnt  <= 2'd0;
        match_cnt <= 8'd0;
        miss_cnt  <= 8'd0;
        locked    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= LOAD;
          end
          LOAD: begin
            if (bit_valid) begin
              sr       <= sr_shift;
              load_cnt <= load_nxt;
              if (load_nxt == 2'd3 && sr_shift != 3'b000) begin
                state     <= VERIFY;
                match_cnt <= 8'd0;
              end
            end
          end
          VERIFY: begin
            if (bit_valid) begin
              // Self-sync: the received bit always enters the window here
              sr <= sr_shift;
              if (sr_shift == 3'b000) begin
                state     <= LOAD;
                sr        <= 3'b000;
                load_cnt  <= 2'd0;
                match_cnt <= 8'd0;
              end else if (bit_in == pred) begin
                match_cnt <= match_cnt + 8'd1;
                if (match_cnt + 8'd1 == LOCK_N) begin
                  state    <= LOCKED;
                  locked   <= 1'b1;
                  miss_cnt <= 8'd0;
                end
              end else begin
                match_cnt <= 8'd0;
              end
            end
          end
          LOCKED: begin
            if (bit_valid) begin
              // Free-running reference: shift the prediction, not the input
              sr <= {sr[1:0], pred};
              if (bit_count != CNT_MAX) bit_count <= bit_count + CNT_W'(1);
              if (bit_in != pred) begin
                err_pulse <= 1'b1;
                if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
                if (miss_cnt + 8'd1 == LOSS_N) begin
                  state    <= LOAD;
                  locked   <= 1'b0;
                  sr       <= 3'b000;
                  load_cnt <= 2'd0;
                  miss_cnt <= 8'd0;
                end else begin
                  miss_cnt <= miss_cnt + 8'd1;
                end
              end else begin
                miss_cnt <= 8'd0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
      if (clr_cnt) begin
        bit_count <= '0;
        err_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pn3_checker.sv
// Randomised and directed bench for pn3_checker against a sequence-lookup model.
module tb_pn3_checker;

  localparam int unsigned CNT_W = 8;
  localparam int CMAX = 255;
  localparam int LOCKN = 7;
  localparam int LOSSN = 3;

  logic clk = 1'b0;
  logic rst_n, enable, bit_in, bit_valid, clr_cnt;
  logic locked, err_pulse;
  logic [CNT_W-1:0] bit_count, err_count;
  logic [2:0] pn_seed;

  int checks = 0;
  int errors = 0;
  int ph = 0;
  bit started = 1'b0;
  int seq [7] = '{0, 0, 1, 1, 1, 0, 1};

  // model state: mode 0 idle, 1 load, 2 verify, 3 locked
  int m_mode, m_win, m_load, m_match, m_miss, m_bc, m_ec, m_pulse;

  pn3_checker #(.LOCK_COUNT(LOCKN), .LOSS_COUNT(LOSSN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bit_in(bit_in),
    .bit_valid(bit_valid), .clr_cnt(clr_cnt), .locked(locked),
    .err_pulse(err_pulse), .bit_count(bit_count), .err_count(err_count),
    .pn_seed(pn_seed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Next PN bit after a 3-bit window, found by locating the window in the period
  function automatic int predict(input int win);
    for (int p = 0; p < 7; p++)
      if (seq[p] * 4 + seq[(p + 1) % 7] * 2 + seq[(p + 2) % 7] == win)
        return seq[(p + 3) % 7];
    return 0;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_step();
    int b, p;
    b = int'(bit_in);
    m_pulse = 0;
    if (!rst_n) begin
      m_mode = 0; m_win = 0; m_load = 0; m_match = 0; m_miss = 0; m_bc = 0; m_ec = 0;
    end else begin
      if (!enable) begin
        m_mode = 0; m_win = 0; m_load = 0; m_match = 0; m_miss = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (bit_valid) begin
        if (m_mode == 1) begin
          m_win = (m_win * 2 + b) % 8;
          m_load = (m_load >= 3) ? 3 : m_load + 1;
          if (m_load == 3 && m_win != 0) begin m_mode = 2; m_match = 0; end
        end else if (m_mode == 2) begin
          p = predict(m_win);
          m_win = (m_win * 2 + b) % 8;
          m_match = (b == p) ? m_match + 1 : 0;
          if (m_win == 0) begin m_mode = 1; m_load = 0; m_match = 0; end
          else if (m_match == LOCKN) begin m_mode = 3; m_miss = 0; end
        end else begin
          p = predict(m_win);
          m_win = (m_win * 2 + p) % 8;
          m_bc = sat(m_bc);
          if (b != p) begin
            m_pulse = 1;
            m_ec = sat(m_ec);
            m_miss++;
            if (m_miss == LOSSN) begin m_mode = 1; m_win = 0; m_load = 0; m_miss = 0; end
          end else begin
            m_miss = 0;
          end
        end
      end
      if (clr_cnt) begin m_bc = 0; m_ec = 0; end
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (started) begin
      chk("locked", int'(locked), (m_mode == 3) ? 1 : 0);
      chk("err_pulse", int'(err_pulse), m_pulse);
      chk("bit_count", int'(bit_count), m_bc);
      chk("err_count", int'(err_count), m_ec);
      chk("pn_seed", int'(pn_seed), m_win);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int b, input int gap);
    bit_in = b[0];
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_clean(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send(seq[ph], gap);
      ph = (ph + 1) % 7;
    end
  endtask

  task automatic send_bad(input int n);
    for (int i = 0; i < n; i++) begin
      send(1 - seq[ph], 0);
      ph = (ph + 1) % 7;
    end
  endtask

  initial begin
    int v;
    rst_n = 1'b0; enable = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clr_cnt = 1'b0;
    tick();
    started = 1'b1;
    tick();
    chk("reset_locked", int'(locked), 0);
    chk("reset_bit_count", int'(bit_count), 0);
    chk("reset_pn_seed", int'(pn_seed), 0);

    // Clean stream from phase 0
    rst_n = 1'b1; enable = 1'b1;
    tick();
    ph = 0;
    send_clean(9, 0);
    chk("clean_locked_bit9", int'(locked), 0);
    send_clean(1, 0);
    chk("clean_locked_bit10", int'(locked), 1);
    chk("clean_seed_bit10", int'(pn_seed), 1);
    send_clean(70, 0);
    chk("clean_bit_count70", int'(bit_count), 70);
    chk("clean_err_count", int'(err_count), 0);
    chk("clean_seed_bit80", int'(pn_seed), 1);

    // Single error
    send_bad(1);
    chk("single_err_pulse", int'(err_pulse), 1);
    chk("single_err_count", int'(err_count), 1);
    chk("single_locked", int'(locked), 1);
    send_clean(1, 0);
    chk("single_pulse_drop", int'(err_pulse), 0);
    send_clean(20, 0);
    chk("single_err_hold", int'(err_count), 1);
    chk("single_bit_count", int'(bit_count), 92);

    // Loss of lock and relock
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    send_bad(2);
    chk("loss_locked_bad2", int'(locked), 1);
    send_bad(1);
    chk("loss_locked_bad3", int'(locked), 0);
    chk("loss_err_count", int'(err_count), 3);
    send_clean(9, 0);
    chk("relock_bit9", int'(locked), 0);
    send_clean(1, 0);
    chk("relock_bit10", int'(locked), 1);

    // Saturation with narrow counters
    send_clean(260, 0);
    chk("sat_bit_count", int'(bit_count), CMAX);

    // clr_cnt coincident with an error
    clr_cnt = 1'b1;
    send_bad(1);
    clr_cnt = 1'b0;
    chk("prio_err_pulse", int'(err_pulse), 1);
    chk("prio_err_count", int'(err_count), 0);
    chk("prio_bit_count", int'(bit_count), 0);

    // Drop enable while locked
    send_clean(2, 0);
    enable = 1'b0;
    tick();
    chk("en_drop_locked", int'(locked), 0);
    chk("en_drop_bit_count", int'(bit_count), 2);
    chk("en_drop_seed", int'(pn_seed), 0);
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;

    // All-zero input
    enable = 1'b1;
    tick();
    for (int i = 0; i < 50; i++) send(0, 0);
    chk("zero_locked", int'(locked), 0);
    chk("zero_seed", int'(pn_seed), 0);
    chk("zero_bit_count", int'(bit_count), 0);
    chk("zero_err_count", int'(err_count), 0);

    // Mid-stream start at phase 3 with strobes every third cycle
    enable = 1'b0; tick(); enable = 1'b1; tick();
    ph = 3;
    send_clean(9, 2);
    chk("gap_locked_bit9", int'(locked), 0);
    send_clean(1, 2);
    chk("gap_locked_bit10", int'(locked), 1);
    send_clean(10, 2);
    chk("gap_bit_count", int'(bit_count), 10);

    // Randomised traffic with errors, clears and enable drops
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 299) != 0);
      clr_cnt = ($urandom_range(0, 63) == 0);
      bit_valid = $urandom_range(0, 1) == 1;
      if (bit_valid) begin
        v = seq[ph] ^ (($urandom_range(0, 19) == 0) ? 1 : 0);
        bit_in = v[0];
        ph = (ph + 1) % 7;
      end
      tick();
    end
    bit_valid = 1'b0; clr_cnt = 1'b0;

    // Reset mid-lock
    enable = 1'b0; tick(); enable = 1'b1; tick();
    send_clean(10, 0);
    chk("rst_pre_locked", int'(locked), 1);
    rst_n = 1'b0; clr_cnt = 1'b0;
    tick();
    chk("rst_locked", int'(locked), 0);
    chk("rst_err_pulse", int'(err_pulse), 0);
    chk("rst_bit_count", int'(bit_count), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_seed", int'(pn_seed), 0);
    tick();
    started = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pn3_checker.md
# pn3_checker

Receive-side checker for the PN3 test pattern (recurrence next = {s[1:0], s[2]^s[0]}, output = s[2], period 7: 0,0,1,1,1,0,1). It sits after the bit slicer or loopback path and consumes one bit per bit_valid strobe. It self-synchronises to the incoming stream, declares lock, then tracks with a free-running local reference while counting received bits and bit errors for link BER measurement.

## Interface
Parameters:
- LOCK_COUNT, 7: consecutive correct predictions required to declare lock (1..255).
- LOSS_COUNT, 3: consecutive mismatches while locked that drop lock (1..255).
- CNT_W, 32: width of bit_count and err_count.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- enable  input  1  checker enable; low forces IDLE.
- bit_in  input  1  received PN bit; sampled only when bit_valid=1.
- bit_valid  input  1  one-cycle strobe per received bit; may be high on consecutive cycles.
- clr_cnt  input  1  synchronous clear of bit_count and err_count.
- locked  output  1  high in LOCKED state.
- err_pulse  output  1  one-cycle pulse per counted bit error.
- bit_count  output  CNT_W  bits checked while locked; saturating.
- err_count  output  CNT_W  errors while locked; saturating.
- pn_seed  output  3  current reference state {s2,s1,s0}.

## Operation
- Reference register sr[2:0] holds the last three bits, oldest in sr[2]. The prediction for the next bit is sr[2]^sr[0]. A generator state equals its next three output bits, so a 3-bit window fully determines phase.
- States: IDLE, LOAD, VERIFY, LOCKED. Internal counters: load_cnt (0..3), match_cnt, miss_cnt.
- IDLE: entered on reset or enable=0. Clears sr, load_cnt, match_cnt, miss_cnt; locked=0. When enable=1, goes to LOAD on the next cycle. bit_count and err_count hold their values.
- LOAD: on each valid bit, sr <= {sr[1:0], bit_in} and load_cnt increments, saturating at 3. Once load_cnt=3 after the shift and the new sr≠000, the state goes to VERIFY with match_cnt=0. If the window is 000, the checker stays in LOAD and keeps sliding.
- VERIFY: on each valid bit, compare bit_in with the prediction, then shift in bit_in (self-sync).
  - Match: match_cnt+1. Reaching LOCK_COUNT moves to LOCKED with miss_cnt=0.
  - Mismatch: match_cnt=0.
  - If the new sr=000: go to LOAD with sr and load_cnt cleared.
- LOCKED: on each valid bit, shift in the predicted bit, not bit_in (free-running reference, so errors do not multiply). bit_count+1.
  - Mismatch: err_count+1, err_pulse=1, miss_cnt+1. Reaching LOSS_COUNT moves to LOAD (sr, load_cnt cleared), and locked falls.
  - Match: miss_cnt=0.
- No counting or err_pulse occurs in LOAD or VERIFY.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clr_cnt has priority over increments: both counters read 0 next cycle, and a coincident bit is not counted. err_pulse still fires for a coincident error.
- enable falling mid-stream: IDLE next cycle, and any in-progress lock is discarded.
- pn_seed = sr in every state.

## Timing
- Reset values: locked=0, err_pulse=0, bit_count=0, err_count=0, pn_seed=000. State is IDLE; the first transition to LOAD occurs on the first cycle with rst_n=1 and enable=1.
- All outputs are registered. The effect of a bit sampled at edge N is visible after edge N (one-cycle latency). err_pulse is high for exactly that one cycle.
- Continuous lock acquisition on a clean stream, counted in valid bits from entering LOAD:
  - 3 bits load.
  - LOCK_COUNT bits verify.
  - locked rises after bit 3+LOCK_COUNT (bit 10 with defaults).
- Loss of lock: locked falls after the LOSS_COUNT-th consecutive bad bit.
- bit_valid gaps of any length are allowed; state holds between strobes.
- rst_n low at any edge overrides everything, including clr_cnt and enable.

## Test plan
- Clean stream: enable=1, bit_valid every cycle, repeating 0011101 from phase 0. Required: locked=0 through bit 9; locked=1 after bit 10. After a further 70 bits, bit_count=70, err_count=0, and pn_seed cycles 001→011→111→110→101→010→100.
- Single error: once locked, invert one bit. Required: one err_pulse, err_count=1, locked stays 1, and no further errors on subsequent clean bits.
- Loss of lock: once locked, invert 3 consecutive bits. Required: err_count=3, locked falls after the 3rd bad bit. The clean stream then relocks 10 valid bits later.
- All-zero input: 50 valid zero bits. Required: state stays LOAD, locked=0, pn_seed=000, both counters 0.
- Mid-stream start and gaps: start at phase 3 (1,1,0,1,0,0,1,...) with bit_valid high every 3rd cycle. Required: lock after 10 valid bits; counters advance only on strobes.
- Control priority: assert clr_cnt on the same cycle as an injected error. Required: err_pulse=1 and err_count=0 next cycle. Drop enable while locked: locked=0 next cycle and counters hold. Assert rst_n low mid-lock: all outputs at reset values next cycle.
